taus_urng_48: RTL and testbench

//  Combined-Tausworthe (taus88) uniform RNG that supplies the 48-bit uniform word consumed by the

---
 rtl/taus_urng_48.sv | 135 +++++++++++++
 tb/tb_taus_urng_48.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/taus_urng_48.sv
// taus_urng_48: two taus88 generators combined into a 48-bit uniform word.
// Define URNG_ZERO_GUARD_EN to replace an all-zero word with 48'h1.
module taus_urng_48 #(
  parameter int WARMUP_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        seed_wr,
  input  logic [31:0] seed_data,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] urng_out
);

  typedef enum logic [1:0] {
    IDLE, SEED, WARMUP, RUN
  } state_t;

  localparam logic [7:0] WLAST = 8'(WARMUP_CYCLES - 1);

  state_t      state, state_nx;
  logic [2:0]  seed_cnt;
  logic [7:0]  warm_cnt;
  logic [31:0] st [6];
  logic [31:0] nx [6];
  logic [31:0] out_a, out_b;
  logic [47:0] raw, word;
  logic        adv, step, cap;
  logic [2:0]  cap_idx;

  function automatic logic [31:0] c0(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFFFFFE) << 12) ^ b;
  endfunction

  function automatic logic [31:0] c1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFFFFF8) << 4) ^ b;
  endfunction

  function automatic logic [31:0] c2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFFFFF0) << 17) ^ b;
  endfunction

  // Forcing the low bits keeps each component above its minimum.
  function automatic logic [31:0] legal(
    input logic [2:0]  idx,
    input logic [31:0] d
  );
    case (idx)
      3'd0, 3'd3: return d | 32'h2;
      3'd1, 3'd4: return d | 32'h8;
      default:    return d | 32'h10;
    endcase
  endfunction

  always_comb begin
    nx[0] = c0(st[0]);
    nx[1] = c1(st[1]);
    nx[2] = c2(st[2]);
    nx[3] = c0(st[3]);
    nx[4] = c1(st[4]);
    nx[5] = c2(st[5]);
    out_a = nx[0] ^ nx[1] ^ nx[2];
    out_b = nx[3] ^ nx[4] ^ nx[5];
    raw   = {out_a, out_b[31:16]};
`ifdef URNG_ZERO_GUARD_EN
    word  = (raw == 48'h0) ? 48'h1 : raw;
`else
    word  = raw;
`endif
  end

  assign adv = (state == RUN) && !seed_wr
            && (!out_valid || out_ready);
  assign step = (state == WARMUP) || adv;
  assign cap = seed_wr && (state != WARMUP);
  assign cap_idx = (state == SEED) ? seed_cnt : 3'd0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (seed_wr) state_nx = SEED;
      SEED:
        if (seed_wr && seed_cnt == 3'd5)
          state_nx = WARMUP;
      WARMUP:
        if (warm_cnt == WLAST) state_nx = RUN;
      RUN:
        if (seed_wr) state_nx = SEED;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SEED) || (state == WARMUP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seed_cnt  <= 3'd0;
      warm_cnt  <= 8'd0;
      out_valid <= 1'b0;
      urng_out  <= 48'h0;
      for (int i = 0; i < 6; i++) st[i] <= 32'h0;
    end else begin
      if (cap) begin
        st[cap_idx] <= legal(cap_idx, seed_data);
        seed_cnt    <= cap_idx + 3'd1;
      end else if (step) begin
        for (int i = 0; i < 6; i++) st[i] <= nx[i];
      end
      if (state == WARMUP) warm_cnt <= warm_cnt + 8'd1;
      else                 warm_cnt <= 8'd0;
      // A reseed drops whatever word is pending.
      if (state == RUN) begin
        if (seed_wr)  out_valid <= 1'b0;
        else if (adv) out_valid <= 1'b1;
      end
      if (adv) urng_out <= word;
    end
  end

endmodule

// File: tb/tb_taus_urng_48.sv
// Bench for taus_urng_48: randomized seeds/ready against a taus88 model.
// Default build (zero guard disabled).
module tb_taus_urng_48;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        seed_wr = 1'b0;
  logic [31:0] seed_data = 32'h0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] urng_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] gs [2][3];
  logic [31:0] seeds [6];
  logic [47:0] cur;

  localparam int Q [3] = '{13, 2, 3};
  localparam int S [3] = '{19, 25, 11};
  localparam int K [3] = '{12, 4, 17};
  localparam logic [31:0] M [3] =
    '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0};
  localparam logic [31:0] L [3] =
    '{32'h2, 32'h8, 32'h10};

  taus_urng_48 #(.WARMUP_CYCLES(16)) dut (
    .clock(clock),
    .reset(reset),
    .seed_wr(seed_wr),
    .seed_data(seed_data),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .urng_out(urng_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic gen_step(input int g, output logic [31:0] o);
    logic [31:0] b;
    o = 32'h0;
    for (int i = 0; i < 3; i++) begin
      b = ((gs[g][i] << Q[i]) ^ gs[g][i]) >> S[i];
      gs[g][i] = ((gs[g][i] & M[i]) << K[i]) ^ b;
      o = o ^ gs[g][i];
    end
  endtask

  task automatic next_word(output logic [47:0] w);
    logic [31:0] a, b;
    gen_step(0, a);
    gen_step(1, b);
    w = {a, b[31:16]};
  endtask

  task automatic model_seed();
    logic [47:0] d;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 3; i++)
        gs[g][i] = seeds[g*3+i] | L[i];
    repeat (16) next_word(d);
    next_word(cur);
  endtask

  task automatic rand_seeds();
    for (int i = 0; i < 6; i++) seeds[i] = $urandom;
  endtask

  task automatic do_seed(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      seed_wr = 1'b1;
      seed_data = seeds[i];
      tick();
    end
    seed_wr = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic stream(input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    wait_valid();
    while (got < n && cyc < n*10 + 100) begin
      chk("valid_held", 64'(out_valid), 64'd1);
      chk("word", 64'(urng_out), 64'(cur));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
      if (out_ready) begin
        got++;
        next_word(cur);
      end
    end
    out_ready = 1'b0;
    chk("stream_count", 64'(got), 64'(n));
  endtask

  initial begin
    int n;
    int bcnt;

    // reset state
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out", 64'(urng_out), 64'd0);
    reset = 1'b0;
    tick();

    // all-zero seeds, latency and first 1000 words
    for (int i = 0; i < 6; i++) seeds[i] = 32'h0;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      seed_wr = 1'b1;
      seed_data = seeds[i];
      tick();
      if (busy) bcnt++;
    end
    seed_wr = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    chk("valid_latency", 64'(n), 64'd17);
    chk("busy_cycles", 64'(bcnt), 64'd21);
    model_seed();
    stream(1000, 1'b0);

    // random ready with random seeds
    rand_seeds();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_seed(0, 5);
    model_seed();
    stream(300, 1'b1);

    // reseed during RUN with a pending word
    chk("pre_reseed_valid", 64'(out_valid), 64'd1);
    rand_seeds();
    seed_wr = 1'b1;
    seed_data = seeds[0];
    tick();
    seed_wr = 1'b0;
    chk("reseed_valid", 64'(out_valid), 64'd0);
    chk("reseed_busy", 64'(busy), 64'd1);
    do_seed(1, 5);
    model_seed();
    stream(60, 1'b1);

    // reset in the middle of warm-up
    rand_seeds();
    do_seed(0, 5);
    repeat (8) tick();
    chk("warm_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wrst_valid", 64'(out_valid), 64'd0);
    chk("wrst_busy", 64'(busy), 64'd0);
    chk("wrst_out", 64'(urng_out), 64'd0);
    tick();
    chk("wrst_idle", 64'(busy), 64'd0);

    // partial seeding holds in SEED
    rand_seeds();
    do_seed(0, 2);
    repeat (100) tick();
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_valid", 64'(out_valid), 64'd0);
    do_seed(3, 5);
    model_seed();
    stream(40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
